// File: rtl/wc_tile_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wc_tile_feeder
// Description : Stream-to-tile front end for the F(4,4) Winograd core.
//               Accepts one signed W-bit sample per handshake and packs
//               overlapping N_IN-sample tiles (stride STRIDE) onto a flat bus
//               that drives the core's D input. Consecutive tiles of a frame
//               share N_IN-STRIDE samples; a frame end zero-pads the last tile.
// Ports       :
//   clk        in   1         rising-edge clock
//   rst        in   1         asynchronous, active-low reset (0 = reset)
//   in_data    in   W         sample (two's complement, passed through as-is)
//   in_valid   in   1         sample valid
//   in_last    in   1         sample is last of its frame (qualified by in_valid)
//   in_ready   out  1         feeder accepts a sample this cycle
//   tile       out  N_IN*W    packed tile; sample j at [(N_IN-j)*W-1 -: W]
//   tile_valid out  1         tile stable and valid
//   tile_last  out  1         tile is the final tile of its frame
//   tile_ready in   1         consumer takes the tile this cycle
//   tile_idx   out  IDX_W     tile number within frame, 0-based
// Revision    : 1.0 - initial release
// ============================================================================
module wc_tile_feeder #(
    parameter int W      = 10,
    parameter int N_IN   = 7,
    parameter int STRIDE = 4,
    parameter int IDX_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [N_IN*W-1:0]   tile,
    output logic                tile_valid,
    output logic                tile_last,
    input  logic                tile_ready,
    output logic [IDX_W-1:0]    tile_idx
);

    localparam int OV    = N_IN - STRIDE;
    localparam int CNT_W = $clog2(N_IN + 1);

    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(N_IN);
    localparam logic [CNT_W-1:0] C_OV   = CNT_W'(OV);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_slots [N_IN];
    logic             r_last;
    logic [IDX_W-1:0] r_idx;

    logic             w_accept;
    logic             w_release;
    logic [CNT_W-1:0] w_cnt_nxt;

    // in_ready is forced low while reset is asserted, not just after the
    // state register has been cleared.
    assign in_ready   = rst && (r_state == S_FILL);
    assign tile_valid = (r_state == S_HOLD);
    assign tile_last  = r_last;
    assign tile_idx   = r_idx;

    assign w_accept   = in_ready && in_valid;
    assign w_release  = tile_valid && tile_ready;
    assign w_cnt_nxt  = r_cnt + 1'b1;

    // Slot 0 (oldest sample of the tile) lands in the most significant field.
    generate
        for (genvar j = 0; j < N_IN; j++) begin : g_pack
            assign tile[(N_IN-j)*W-1 -: W] = r_slots[j];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_idx   <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        // Write the new sample; on a short frame end, zero
                        // every slot above it in the same edge so the tile is
                        // complete one cycle after the last accept.
                        for (int i = 0; i < N_IN; i++) begin
                            if (CNT_W'(i) == r_cnt) begin
                                r_slots[i] <= in_data;
                            end else if (in_last && (CNT_W'(i) > r_cnt)) begin
                                r_slots[i] <= '0;
                            end
                        end
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == C_FULL) begin
                            r_state <= S_HOLD;
                            r_last  <= in_last;
                        end else if (in_last) begin
                            r_state <= S_HOLD;
                            r_last  <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_release) begin
                        r_state <= S_FILL;
                        r_last  <= 1'b0;
                        if (r_last) begin
                            // Frame boundary: nothing carries into the next frame.
                            r_cnt <= '0;
                            r_idx <= '0;
                            for (int i = 0; i < N_IN; i++) begin
                                r_slots[i] <= '0;
                            end
                        end else begin
                            // Slide the window: the newest OV samples become
                            // the head of the next tile.
                            r_cnt <= C_OV;
                            r_idx <= r_idx + 1'b1;
                            for (int i = 0; i < N_IN; i++) begin
                                if (i < OV) begin
                                    r_slots[i] <= r_slots[i + STRIDE];
                                end else begin
                                    r_slots[i] <= '0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
